gcd_controller: RTL and testbench

Control FSM that sequences the 16-bit subtractive GCD datapath (A/B registers, operand muxes, load mux, subtractor, comparator). It accepts a start request, steers two operands from `data_in` into registers A and B, and repeatedly subtracts the smaller register from the larger until the comparator reports equality. It then signals completion; the result is held in register A. An iteration counter with a configurable limit bounds the run, so a zero operand or a runaway cannot hang the block.

---
 rtl/gcd_controller.sv | 125 ++++++++++++
 tb/tb_gcd_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for a 16-bit subtractive GCD datapath.
// Ports: start/gt/lt/eq in; ldA/ldB/sel1/sel2/sel_in/want_a/want_b decoded
// from state and flags; busy/done/timeout/iter_cnt registered.
module gcd_controller #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             want_a,
  output logic             want_b,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

  state_t state;

  logic at_limit;
  assign at_limit = (iter_cnt == ITER_LIMIT);

  // Datapath steering. In RUN the load is suppressed on equality or at the
  // iteration limit so the final register contents are left untouched.
  always_comb begin
    ldA    = 1'b0;
    ldB    = 1'b0;
    sel1   = 1'b0;
    sel2   = 1'b0;
    sel_in = 1'b0;
    want_a = 1'b0;
    want_b = 1'b0;
    case (state)
      S_LOAD_A: begin
        sel_in = 1'b1;
        ldA    = 1'b1;
        want_a = 1'b1;
      end
      S_LOAD_B: begin
        sel_in = 1'b1;
        ldB    = 1'b1;
        want_b = 1'b1;
      end
      S_RUN: begin
        if (!eq && !at_limit) begin
          if (gt) begin
            // A <- A - B
            sel2 = 1'b1;
            ldA  = 1'b1;
          end else if (lt) begin
            // B <- B - A
            sel1 = 1'b1;
            ldB  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      iter_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_A;
            busy     <= 1'b1;
            iter_cnt <= '0;
            timeout  <= 1'b0;
          end
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_LOAD_B: state <= S_RUN;
        S_RUN: begin
          if (eq) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (at_limit) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            // Counted even if no flag is set, so a broken comparator still
            // ends in a timeout instead of spinning forever. The limit check
            // above keeps the counter from wrapping.
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_controller.sv
module tb_gcd_controller;

  localparam int CNT_W    = 16;
  localparam int MAX_ITER = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             gt, lt, eq;
  logic             ldA, ldB, sel1, sel2, sel_in, want_a, want_b;
  logic             busy, done, timeout;
  logic [CNT_W-1:0] iter_cnt;

  gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start),
    .gt(gt), .lt(lt), .eq(eq),
    .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .want_a(want_a), .want_b(want_b),
    .busy(busy), .done(done), .timeout(timeout), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath environment: operand source, muxes, subtractor, registers, comparator.
  logic [15:0] cur_a = 16'd0, cur_b = 16'd0;
  logic [15:0] a_reg, b_reg, data_in, mux_m, mux_s, bus;
  assign data_in = want_a ? cur_a : (want_b ? cur_b : 16'd0);
  assign mux_m   = sel1 ? b_reg : a_reg;
  assign mux_s   = sel2 ? b_reg : a_reg;
  assign bus     = sel_in ? data_in : (mux_m - mux_s);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= 16'd0;
      b_reg <= 16'd0;
    end else begin
      if (ldA) a_reg <= bus;
      if (ldB) b_reg <= bus;
    end
  end
  assign gt = a_reg > b_reg;
  assign lt = a_reg < b_reg;
  assign eq = a_reg == b_reg;

  typedef struct {
    int          start_cyc;
    logic [15:0] res;
    int          n;
    int          to;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] euclid(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference: number of subtractions the rule "larger minus smaller until
  // equal" needs, capped at MAX_ITER; result is the Euclidean GCD.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int sc);
    exp_t e;
    logic [15:0] x, y;
    int n;
    x = a;
    y = b;
    n = 0;
    while (x != y && n < MAX_ITER) begin
      if (x > y) x = x - y;
      else y = y - x;
      n++;
    end
    e.start_cyc = sc;
    e.n         = n;
    e.to        = (x != y) ? 1 : 0;
    e.res       = euclid(a, b);
    return e;
  endfunction

  // Monitor: counts subtraction loads and checks each completion.
  int   sub_cnt = 0;
  exp_t got_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sub_cnt = 0;
      end else begin
        if (want_a) sub_cnt = 0;
        if ((ldA || ldB) && !sel_in) sub_cnt++;
        if (done) begin
          if (expq.size() == 0) begin
            chk("spurious_done", int'(done), 0);
          end else begin
            got_e = expq.pop_front();
            chk("done_latency", cyc - got_e.start_cyc, got_e.n + 4);
            chk("iter_cnt", int'(iter_cnt), got_e.n);
            chk("timeout", int'(timeout), got_e.to);
            chk("sub_loads", sub_cnt, got_e.n);
            chk("busy_in_done", int'(busy), 0);
            if (got_e.to == 0) chk("result_a", int'(a_reg), int'(got_e.res));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && expq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (expq.size() != 0) begin
      chk("done_wait_expired", expq.size(), 0);
      expq.delete();
    end
  endtask

  // One start pulse; returns in cycle 1 after checking the launch state.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    #1;
    cur_a = a;
    cur_b = b;
    start = 1'b1;
    expq.push_back(model(a, b, cyc));
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("launch_busy", int'(busy), 1);
    chk("launch_want_a", int'(want_a), 1);
    chk("launch_iter_clr", int'(iter_cnt), 0);
    chk("launch_timeout_clr", int'(timeout), 0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    issue(a, b);
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, int'({ldA, ldB, sel1, sel2, sel_in, want_a, want_b}), 0);
    chk({tag, "_flags"}, int'({busy, done, timeout}), 0);
    chk({tag, "_iter"}, int'(iter_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_op(16'd12, 16'd8);   // basic, N=2
    run_op(16'd9, 16'd9);    // equal operands, N=0
    run_op(16'd13, 16'd1);   // long coprime run, N=12
    run_op(16'd7, 16'd0);    // zero operand -> timeout at 16
    run_op(16'd5, 16'd5);    // new start clears timeout
    run_op(16'd0, 16'd0);    // both zero -> immediate eq

    // Reset in the middle of a run.
    issue(16'd100, 16'd3);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    expq.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    run_op(16'd6, 16'd4);

    // A start pulse during RUN must be ignored.
    issue(16'd30, 16'd4);
    repeat (3) @(negedge clk);
    #1;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("no_queued_start", int'(busy), 0);
    end

    // Start held high: a second run launches right after DONE.
    @(negedge clk);
    #1;
    cur_a = 16'd13;
    cur_b = 16'd1;
    start = 1'b1;
    expq.push_back(model(16'd13, 16'd1, cyc));
    wait_idle();
    cur_a = 16'd21;
    cur_b = 16'd15;
    expq.push_back(model(16'd21, 16'd15, cyc + 1));
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("b2b_want_a", int'(want_a), 1);
    wait_idle();

    // Randomized operands, a mix of small and wide values.
    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      if (i % 3 == 0) begin
        ra = 16'($urandom_range(0, 65535));
        rb = 16'($urandom_range(0, 65535));
      end else begin
        ra = 16'($urandom_range(0, 40));
        rb = 16'($urandom_range(0, 40));
      end
      run_op(ra, rb);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
